// File: rtl/eth_bridge_pkg.sv
// Shared Ethernet bridge constants and the transmit scheduler state encoding.
// Used by the receive path, the frame buffers and the transmit scheduler.
package eth_bridge_pkg;

  localparam int LEN_W         = 16;
  localparam int MIN_FRAME_LEN = 60;
  localparam int MAX_FRAME_LEN = 1514;
  localparam int IFG_CYCLES    = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_PAD  = 3'd3,
    ST_DROP = 3'd4,
    ST_GAP  = 3'd5
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
// Rotate requests down by ptr, take the lowest set bit, rotate the grant back.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] gnt_dbl;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   gnt_rot;

  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[N-1:0];
    gnt_rot = req_rot & (~req_rot + N'(1));
    gnt_dbl = {gnt_rot, gnt_rot} << ptr;
    gnt     = gnt_dbl[2*N-1:N];
  end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Transmit frame scheduler: round-robin pick of a buffered frame, stream it to
// the MAC, pad short frames, drop illegal lengths and enforce the idle gap.
module tx_frame_scheduler #(
  parameter int NUM_SRC    = 2,
  parameter int LEN_W      = eth_bridge_pkg::LEN_W,
  parameter int MIN_LEN    = eth_bridge_pkg::MIN_FRAME_LEN,
  parameter int MAX_LEN    = eth_bridge_pkg::MAX_FRAME_LEN,
  parameter int IFG_CYCLES = eth_bridge_pkg::IFG_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         src_len_empty,
  input  logic [NUM_SRC*LEN_W-1:0]   src_len,
  output logic [NUM_SRC-1:0]         src_len_rd,
  input  logic [NUM_SRC-1:0]         src_data_empty,
  input  logic [NUM_SRC*8-1:0]       src_data,
  output logic [NUM_SRC-1:0]         src_data_rd,
  output logic [7:0]                 mac_data,
  output logic                       mac_valid,
  output logic                       mac_last,
  input  logic                       mac_ready,
  output logic [NUM_SRC-1:0]         grant,
  output logic                       busy,
  output logic                       len_err,
  output eth_bridge_pkg::sched_state_e dbg_state
);

  import eth_bridge_pkg::*;

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int GAP_W = $clog2(IFG_CYCLES + 1);

  sched_state_e       state, state_next;
  logic [NUM_SRC-1:0] grant_q, grant_next;
  logic [PTR_W-1:0]   sel_q, sel_next;
  logic [PTR_W-1:0]   rr_ptr, rr_next;
  logic [LEN_W-1:0]   len_q, len_next;
  logic [LEN_W-1:0]   tgt_q, tgt_next;
  logic [LEN_W-1:0]   cnt_q, cnt_next;
  logic [GAP_W-1:0]   gap_q, gap_next;

  logic [NUM_SRC-1:0] arb_gnt;
  logic [PTR_W-1:0]   win_idx;
  logic [LEN_W-1:0]   head_len;
  logic [7:0]         head_data;
  logic               data_avail;
  logic               at_last;

  rr_arbiter #(.N(NUM_SRC), .PTR_W(PTR_W)) u_arb (
    .req (~src_len_empty),
    .ptr (rr_ptr),
    .gnt (arb_gnt)
  );

  // Binary index of the arbiter winner and FIFO heads of the current owner.
  always_comb begin
    win_idx    = '0;
    head_len   = '0;
    head_data  = '0;
    data_avail = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (arb_gnt[i]) win_idx = PTR_W'(i);
      if (sel_q == PTR_W'(i)) begin
        head_len   = src_len[i*LEN_W +: LEN_W];
        head_data  = src_data[i*8 +: 8];
        data_avail = !src_data_empty[i];
      end
    end
  end

  assign at_last   = (cnt_q == tgt_q - LEN_W'(1));
  assign grant     = grant_q;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  // MAC handshake: a byte transfers on every cycle with mac_valid && mac_ready;
  // an offered byte stays unchanged until it transfers because the FIFO head
  // only moves on a pop.
  always_comb begin
    state_next  = state;
    grant_next  = grant_q;
    sel_next    = sel_q;
    rr_next     = rr_ptr;
    len_next    = len_q;
    tgt_next    = tgt_q;
    cnt_next    = cnt_q;
    gap_next    = gap_q;
    src_len_rd  = '0;
    src_data_rd = '0;
    mac_data    = 8'h00;
    mac_valid   = 1'b0;
    mac_last    = 1'b0;
    len_err     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (|arb_gnt) begin
          grant_next = arb_gnt;
          sel_next   = win_idx;
          rr_next    = (win_idx == PTR_W'(NUM_SRC - 1)) ? '0 : win_idx + PTR_W'(1);
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        src_len_rd[sel_q] = 1'b1;
        len_next          = head_len;
        cnt_next          = '0;
        if (head_len == '0) begin
          len_err    = 1'b1;
          grant_next = '0;
          state_next = ST_IDLE;
        end else if (head_len > LEN_W'(MAX_LEN)) begin
          len_err    = 1'b1;
          state_next = ST_DROP;
        end else begin
          tgt_next   = (head_len < LEN_W'(MIN_LEN)) ? LEN_W'(MIN_LEN) : head_len;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        mac_valid = data_avail;
        mac_data  = head_data;
        mac_last  = data_avail && at_last;
        if (data_avail && mac_ready) begin
          src_data_rd[sel_q] = 1'b1;
          cnt_next           = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            if (len_q >= LEN_W'(MIN_LEN)) begin
              grant_next = '0;
              gap_next   = '0;
              state_next = ST_GAP;
            end else begin
              state_next = ST_PAD;
            end
          end
        end
      end
      ST_PAD: begin
        mac_valid = 1'b1;
        mac_last  = at_last;
        if (mac_ready) begin
          cnt_next = cnt_q + LEN_W'(1);
          if (at_last) begin
            grant_next = '0;
            gap_next   = '0;
            state_next = ST_GAP;
          end
        end
      end
      ST_DROP: begin
        if (data_avail) begin
          src_data_rd[sel_q] = 1'b1;
          cnt_next           = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            grant_next = '0;
            state_next = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        gap_next = gap_q + GAP_W'(1);
        if (gap_q == GAP_W'(IFG_CYCLES - 1)) state_next = ST_IDLE;
      end
      default: begin
        grant_next = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q <= '0;
      sel_q   <= '0;
      rr_ptr  <= '0;
      len_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      grant_q <= grant_next;
      sel_q   <= sel_next;
      rr_ptr  <= rr_next;
      len_q   <= len_next;
      tgt_q   <= tgt_next;
      cnt_q   <= cnt_next;
      gap_q   <= gap_next;
    end
  end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Bench for tx_frame_scheduler: queue-backed source FIFOs, a frame-level
// reference model producing the expected beat and grant sequences, and a
// per-cycle compare process.
module tb_tx_frame_scheduler;
  import eth_bridge_pkg::*;

  localparam int IFG   = 12;
  localparam int MIN_L = 60;
  localparam int MAX_L = 1514;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  src_len_empty, src_len_rd, src_data_empty, src_data_rd, grant;
  logic [31:0] src_len;
  logic [15:0] src_data;
  logic [7:0]  mac_data;
  logic        mac_valid, mac_last, mac_ready, busy, len_err;
  sched_state_e dbg_state;

  // source FIFO contents and the model's private copy of the same frames
  logic [15:0] lq0[$], lq1[$], mlq0[$], mlq1[$];
  logic [7:0]  dq0[$], dq1[$], mdq0[$], mdq1[$];
  logic [8:0]  exp_q[$];
  logic [1:0]  exp_g[$];

  int n_checks = 0, n_pass = 0;
  int cyc = 0, ready_pct = 100, m_ptr = 0;
  int n_err, n_len_rd, n_last, m_err, m_len_rd, m_frames_tx;
  int pops[2], m_pops[2];
  int idle_run = 0, last_cyc = 0, push_cyc = 0;
  bit in_frame = 0, prev_stall = 0, have_last = 0, gap_armed = 0;
  bit lat_armed = 0, exact_gap = 0;
  logic [7:0] prev_data;
  logic       prev_last;
  logic [1:0] cur_grant, pend_len_rd = '0, pend_data_rd = '0;

  tx_frame_scheduler dut (
    .clk(clk), .rst(rst),
    .src_len_empty(src_len_empty), .src_len(src_len), .src_len_rd(src_len_rd),
    .src_data_empty(src_data_empty), .src_data(src_data), .src_data_rd(src_data_rd),
    .mac_data(mac_data), .mac_valid(mac_valid), .mac_last(mac_last), .mac_ready(mac_ready),
    .grant(grant), .busy(busy), .len_err(len_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- source FIFO driver ----------------
  task automatic refresh();
    src_len_empty  = {lq1.size() == 0, lq0.size() == 0};
    src_data_empty = {dq1.size() == 0, dq0.size() == 0};
    src_len  = '0;
    src_data = '0;
    if (lq0.size() > 0) src_len[15:0]   = lq0[0];
    if (lq1.size() > 0) src_len[31:16]  = lq1[0];
    if (dq0.size() > 0) src_data[7:0]   = dq0[0];
    if (dq1.size() > 0) src_data[15:8]  = dq1[0];
  endtask

  always @(posedge clk) begin
    #1;
    if (pend_len_rd[0]  && lq0.size() > 0) void'(lq0.pop_front());
    if (pend_len_rd[1]  && lq1.size() > 0) void'(lq1.pop_front());
    if (pend_data_rd[0] && dq0.size() > 0) void'(dq0.pop_front());
    if (pend_data_rd[1] && dq1.size() > 0) void'(dq1.pop_front());
    pend_len_rd  = '0;
    pend_data_rd = '0;
    mac_ready = ($urandom_range(0, 99) < ready_pct);
    refresh();
  end

  task automatic push_frame(input int s, input int len, input bit inc);
    logic [7:0] b;
    if (s == 0) begin lq0.push_back(16'(len)); mlq0.push_back(16'(len)); end
    else        begin lq1.push_back(16'(len)); mlq1.push_back(16'(len)); end
    for (int i = 0; i < len; i++) begin
      b = inc ? 8'(i) : 8'($urandom_range(0, 255));
      if (s == 0) begin dq0.push_back(b); mdq0.push_back(b); end
      else        begin dq1.push_back(b); mdq1.push_back(b); end
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  function automatic int mq_size(input int c);
    return (c == 0) ? mlq0.size() : mlq1.size();
  endfunction

  task automatic model_build();
    int s, c, len, tgt;
    logic [7:0] b;
    while (mlq0.size() + mlq1.size() > 0) begin
      s = -1;
      for (int k = 0; k < 2; k++) begin
        c = (m_ptr + k) % 2;
        if (s < 0 && mq_size(c) > 0) s = c;
      end
      m_ptr = (s + 1) % 2;
      if (s == 0) len = int'(mlq0.pop_front());
      else        len = int'(mlq1.pop_front());
      m_len_rd++;
      tgt = (len < MIN_L) ? MIN_L : len;
      if (len == 0 || len > MAX_L) m_err++;
      if (len > MAX_L) tgt = 0;
      else if (len > 0) begin
        exp_g.push_back(2'(1 << s));
        m_frames_tx++;
      end
      if (len > 0) m_pops[s] += len;
      for (int i = 0; i < len; i++) begin
        if (s == 0) b = mdq0.pop_front();
        else        b = mdq1.pop_front();
        if (len <= MAX_L) exp_q.push_back({i == tgt - 1, b});
      end
      if (len > 0) for (int i = len; i < tgt; i++) exp_q.push_back({i == tgt - 1, 8'h00});
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst) begin
      pend_len_rd = '0; pend_data_rd = '0;
      prev_stall = 0; in_frame = 0; have_last = 0; gap_armed = 0;
    end else begin
      pend_len_rd  = src_len_rd;
      pend_data_rd = src_data_rd;
      n_len_rd += $countones(src_len_rd);
      n_err    += int'(len_err);
      for (int s = 0; s < 2; s++)
        if (src_data_rd[s]) begin
          pops[s]++;
          check_eq("pop_nonempty", (s == 0) ? dq0.size() > 0 : dq1.size() > 0, 1);
        end
      if (gap_armed && !busy) begin
        check_eq("ifg_busy_cycles", cyc - last_cyc, IFG + 1);
        gap_armed = 0;
      end
      if (prev_stall)
        check_eq("stall_hold", {mac_valid, mac_last, mac_data}, {1'b1, prev_last, prev_data});
      if (mac_valid) begin
        check_eq("valid_has_expect", exp_q.size() > 0, 1);
        if (!in_frame) begin
          in_frame = 1;
          cur_grant = grant;
          if (exp_g.size() > 0) check_eq("grant_order", grant, exp_g.pop_front());
          else check_eq("grant_expected_frame", 0, 1);
          if (lat_armed) begin
            check_eq("first_beat_latency", cyc - push_cyc, 2);
            lat_armed = 0;
          end
          if (have_last) begin
            check_eq("ifg_min_spacing", idle_run >= IFG + 2, 1);
            if (exact_gap) check_eq("ifg_exact_spacing", idle_run, IFG + 2);
          end
        end else check_eq("grant_steady", grant, cur_grant);
        if (mac_ready && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("beat", {mac_last, mac_data}, e);
          if (mac_last) begin
            n_last++; in_frame = 0; have_last = 1; idle_run = 0;
            last_cyc = cyc; gap_armed = 1;
          end
        end
        prev_stall = !mac_ready;
        prev_data  = mac_data;
        prev_last  = mac_last;
      end else begin
        prev_stall = 0;
        if (!in_frame) idle_run++;
      end
    end
  end

  // ---------------- scenario helpers ----------------
  task automatic scen_begin(input int pct);
    ready_pct = pct;
    n_err = 0; n_len_rd = 0; n_last = 0;
    m_err = 0; m_len_rd = 0; m_frames_tx = 0;
    pops[0] = 0; pops[1] = 0; m_pops[0] = 0; m_pops[1] = 0;
    have_last = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (n < budget && !(exp_q.size() == 0 && !busy && lq0.size() == 0 &&
           lq1.size() == 0 && dq0.size() == 0 && dq1.size() == 0)) begin
      @(posedge clk); #2;
      n++;
    end
    check_eq("scenario_in_budget", n < budget, 1);
  endtask

  task automatic scen_end();
    check_eq("grants_left", exp_g.size(), 0);
    check_eq("len_err_count", n_err, m_err);
    check_eq("len_pop_count", n_len_rd, m_len_rd);
    check_eq("last_count", n_last, m_frames_tx);
    check_eq("byte_pops_src0", pops[0], m_pops[0]);
    check_eq("byte_pops_src1", pops[1], m_pops[1]);
  endtask

  task automatic start_scen();
    @(posedge clk); #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; mac_ready = 1'b0;
    refresh();
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_outputs", {mac_valid, mac_last, mac_data, grant, busy, len_err,
                             src_len_rd, src_data_rd}, 0);
    check_eq("rst_state_idle", dbg_state == ST_IDLE, 1);
    start_scen();
    rst = 1'b1;

    // one 64-byte frame on src0, incrementing data
    start_scen(); scen_begin(100);
    push_frame(0, 64, 1); model_build(); refresh();
    check_eq("model_s1_beats", exp_q.size(), 64);
    check_eq("model_s1_last", exp_q[63], {1'b1, 8'd63});
    push_cyc = cyc; lat_armed = 1;
    wait_done(1000); scen_end();

    // short frame on src1 padded to the minimum
    start_scen(); scen_begin(100);
    push_frame(1, 10, 0); model_build(); refresh();
    check_eq("model_s2_beats", exp_q.size(), 60);
    check_eq("model_s2_pad", exp_q[10], {1'b0, 8'h00});
    check_eq("model_s2_last", exp_q[59][8], 1);
    check_eq("model_s2_pops", m_pops[1], 10);
    wait_done(1000); scen_end();

    // both sources with three 60-byte frames each
    start_scen(); scen_begin(100); exact_gap = 1;
    for (int k = 0; k < 3; k++) begin push_frame(0, 60, 0); push_frame(1, 60, 0); end
    model_build(); refresh();
    for (int k = 0; k < 6; k++) check_eq("model_s3_grant", exp_g[k], (k % 2 == 0) ? 1 : 2);
    wait_done(3000); scen_end(); exact_gap = 0;

    // 100-byte frame with a 50% ready pattern
    start_scen(); scen_begin(50);
    push_frame(0, 100, 0); model_build(); refresh();
    wait_done(2000); scen_end();

    // zero length and oversize ahead of a good frame
    start_scen(); scen_begin(100);
    push_frame(0, 0, 0); push_frame(0, 2000, 0); push_frame(0, 60, 1);
    model_build(); refresh();
    check_eq("model_s5_err", m_err, 2);
    check_eq("model_s5_pops", m_pops[0], 2060);
    check_eq("model_s5_beats", exp_q.size(), 60);
    wait_done(5000); scen_end();

    // randomized mix of lengths and sources
    start_scen(); scen_begin(70);
    for (int k = 0; k < 10; k++) begin
      int r, len;
      r = $urandom_range(0, 9);
      if (r == 0)      len = 0;
      else if (r == 1) len = 1515 + $urandom_range(0, 40);
      else if (r < 6)  len = $urandom_range(1, 59);
      else             len = $urandom_range(60, 300);
      push_frame($urandom_range(0, 1), len, 0);
    end
    model_build(); refresh();
    wait_done(30000); scen_end();

    // asynchronous reset during beat 30 of a 64-byte frame
    start_scen(); scen_begin(100);
    push_frame(0, 64, 1); model_build(); refresh();
    begin
      int n = 0;
      while (exp_q.size() > 35 && n < 500) begin @(posedge clk); #2; n++; end
      check_eq("reached_beat_30", exp_q.size(), 35);
    end
    rst = 1'b0;
    #1;
    check_eq("async_rst_outputs", {mac_valid, mac_last, mac_data, grant, busy, len_err,
                                   src_len_rd, src_data_rd}, 0);
    lq0.delete(); lq1.delete(); dq0.delete(); dq1.delete();
    mlq0.delete(); mlq1.delete(); mdq0.delete(); mdq1.delete();
    exp_q.delete(); exp_g.delete(); m_ptr = 0;
    refresh();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    start_scen(); scen_begin(100);
    push_frame(1, 60, 0); push_frame(0, 60, 0); model_build(); refresh();
    check_eq("model_s7_first_grant", exp_g[0], 1);
    push_cyc = cyc; lat_armed = 1;
    wait_done(2000); scen_end();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_frame_scheduler.md
# tx_frame_scheduler

Transmit-side frame scheduler for the Ethernet bridge. Sits between the per-port receive frame buffers (a length FIFO plus a byte FIFO per source) and the single transmit MAC byte interface. It picks one pending frame by round-robin, pops its length word and streams exactly that many bytes to the MAC under a valid/ready handshake. It pads short frames to the minimum length, drops illegal lengths and enforces an inter-frame idle gap.

## Interface
- NUM_SRC, 2: number of source buffers; 2..8.
- LEN_W, 16: length word width.
- MIN_LEN, 60: minimum emitted frame length in bytes; FCS is excluded and appended by the MAC.
- MAX_LEN, 1514: largest legal length; larger frames are dropped.
- IFG_CYCLES, 12: idle cycles enforced after each frame's last beat.

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- src_len_empty  in  NUM_SRC  per-source length FIFO empty
- src_len  in  NUM_SRC*LEN_W  per-source length FIFO head (first-word-fall-through)
- src_len_rd  out  NUM_SRC  length pop, one-cycle pulse
- src_data_empty  in  NUM_SRC  per-source byte FIFO empty
- src_data  in  NUM_SRC*8  per-source byte FIFO head (FWFT)
- src_data_rd  out  NUM_SRC  byte pop
- mac_data  out  8  byte to MAC
- mac_valid  out  1  mac_data valid
- mac_last  out  1  final byte of frame, qualified by mac_valid
- mac_ready  in  1  MAC accepts the byte this cycle
- grant  out  NUM_SRC  one-hot owner of the current frame; 0 when idle
- busy  out  1  state != IDLE
- len_err  out  1  one-cycle pulse when a length is dropped

## Operation
- States: IDLE, LOAD, SEND, PAD, DROP, GAP.
- IDLE:
  - If any source has !src_len_empty, the round-robin arbiter selects the first requester at or after rr_ptr.
  - The winner is registered into grant; next state is LOAD.
  - rr_ptr is set to winner+1, modulo NUM_SRC.
- LOAD:
  - Latch len from the granted src_len and pulse src_len_rd[g].
  - Clear cnt.
  - len==0: pulse len_err, go to IDLE.
  - len>MAX_LEN: pulse len_err, go to DROP.
  - Otherwise: tgt = max(len, MIN_LEN), go to SEND.
- SEND:
  - mac_valid = !src_data_empty[g]; mac_data = src_data[g].
  - src_data_rd[g] = mac_valid && mac_ready.
  - Each handshake increments cnt.
  - mac_last = (cnt == tgt-1).
  - When cnt reaches len-1 on a handshake: go to GAP if len >= MIN_LEN, else go to PAD.
- PAD:
  - mac_valid = 1, mac_data = 8'h00; no byte pops.
  - Each handshake increments cnt; mac_last = (cnt == tgt-1).
  - The last handshake moves the state to GAP.
- DROP: pop one byte from src_data[g] per cycle while not empty, with no MAC activity, until len bytes have been popped; then go to IDLE.
- GAP: gap counter counts IFG_CYCLES cycles, then next state is IDLE. grant is cleared on entry.
- cnt and len are LEN_W bits wide; tgt-1 is computed in LEN_W bits. LOAD rejects len==0, so tgt-1 never underflows.
- Source underrun in SEND: mac_valid drops and the stream resumes when data arrives. There is no timeout; upstream guarantees whole frames are buffered before their length word is written.
- mac_data, mac_valid and mac_last stay stable while mac_valid && !mac_ready. This holds because the FWFT head does not change without a pop.

## Timing
- Outputs are combinational from registered state and the FIFO heads. There are no registered output stages.
- Reset values (async, all asserted low-reset):
  - mac_valid, mac_last, grant, busy, len_err, src_len_rd and src_data_rd are all 0.
  - mac_data = 0.
  - rr_ptr = 0, state = IDLE.
- Latency: the length word present in IDLE gives LOAD on the next cycle; the first mac_valid comes in the cycle after LOAD, provided data is present.
  - Total is 2 cycles from the length becoming visible to the first byte.
- Throughput: 1 byte per cycle with mac_ready held high.
- After a mac_last handshake: IFG_CYCLES cycles in GAP plus 1 cycle in IDLE before the next LOAD. The minimum spacing from last beat to the next first beat is IFG_CYCLES+2 cycles.
- Simultaneous requests are resolved in IDLE only. A request arriving mid-frame waits.
- Reset mid-frame: return to IDLE immediately with all outputs at 0. Any partially consumed frame is lost, so upstream FIFOs must share rst.

## Structure
- Shared package eth_bridge_pkg holds:
  - LEN_W, MIN_FRAME_LEN (60), MAX_FRAME_LEN (1514) and IFG_CYCLES, shared with the receive path and buffers.
  - The state encoding.
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr; output one-hot gnt. Purely combinational rotate/priority/rotate-back logic.

## Test plan
- src0 holds one frame, len=64, bytes 0..63; mac_ready=1:
  - 64 beats with data 0..63 and mac_last on beat 64.
  - One src_len_rd[0] pulse and 64 src_data_rd[0] pops.
  - mac_valid low for the next IFG_CYCLES+1 cycles.
- src1, len=10:
  - 10 data beats, then 50 beats of 0x00; mac_last on beat 60.
  - Exactly 10 byte pops.
- Both sources pending with 3 frames each (len 60):
  - grant sequence 01,10,01,10,01,10.
  - No frame interleaving within a frame.
- Frame of len=100 with mac_ready driven by a random 50% pattern:
  - Every beat is held stable while stalled.
  - Sequence is bit-exact with no duplicates or losses.
  - mac_last appears exactly once.
- len=0 and len=2000 queued ahead of a len=60 frame on src0:
  - Two len_err pulses; 2000 bytes popped with mac_valid never high during the drop.
  - The following 60-byte frame is then sent intact.
- rst asserted low during beat 30 of a 64-byte frame:
  - All outputs go to 0 asynchronously and rr_ptr=0.
  - After release with fresh FIFOs, the next frame is sent normally from src0.
